// File: rtl/multdiv_scheduler_pkg.sv
// Shared MD-unit constants: operation codes, op width, default latencies and FSM state type.
// Imported by the decoder-facing interface, the scheduler and the multiply/divide ALU,
// so the decoder and the scheduler agree on the encoding.
package multdiv_scheduler_pkg;

  localparam int unsigned MdOpW = 4;

  localparam logic [MdOpW-1:0] OpNone  = 4'd0;
  localparam logic [MdOpW-1:0] OpMult  = 4'd1;
  localparam logic [MdOpW-1:0] OpMultu = 4'd2;
  localparam logic [MdOpW-1:0] OpDiv   = 4'd3;
  localparam logic [MdOpW-1:0] OpDivu  = 4'd4;
  localparam logic [MdOpW-1:0] OpMthi  = 4'd5;
  localparam logic [MdOpW-1:0] OpMtlo  = 4'd6;
  localparam logic [MdOpW-1:0] OpMadd  = 4'd7;
  localparam logic [MdOpW-1:0] OpMaddu = 4'd8;
  localparam logic [MdOpW-1:0] OpMsub  = 4'd9;
  localparam logic [MdOpW-1:0] OpMsubu = 4'd10;

  localparam int unsigned DefaultMultCycles = 5;
  localparam int unsigned DefaultDivCycles  = 10;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

  // Multiply-class ops that occupy the unit for the multiply latency.
  function automatic logic is_mul_op(logic [MdOpW-1:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu) ||
           (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_div_op(logic [MdOpW-1:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/multdiv_scheduler_if.sv
// E-stage multiply/divide issue interface.
// master: issuing side (pipeline/hazard logic) drives start_E, multdivop_E, rs_E, rt_E,
//         md_use_D (and cancel_E when MULTDIV_CANCEL_EN is defined).
// slave:  MD scheduler returns busy, stall_md and the architectural hi/lo.
interface multdiv_scheduler_if;
  import multdiv_scheduler_pkg::*;

  logic             start_E;
  logic [MdOpW-1:0] multdivop_E;
  logic [31:0]      rs_E;
  logic [31:0]      rt_E;
  logic             md_use_D;
`ifdef MULTDIV_CANCEL_EN
  logic             cancel_E;
`endif
  logic             busy;
  logic             stall_md;
  logic [31:0]      hi;
  logic [31:0]      lo;

  modport master (
    output start_E, multdivop_E, rs_E, rt_E, md_use_D,
`ifdef MULTDIV_CANCEL_EN
    output cancel_E,
`endif
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start_E, multdivop_E, rs_E, rt_E, md_use_D,
`ifdef MULTDIV_CANCEL_EN
    input  cancel_E,
`endif
    output busy, stall_md, hi, lo
  );

endinterface

// File: rtl/multdiv_alu.sv
// Combinational HI/LO result generator for the MD unit.
// Ports: op (operation code), rs/rt (operands), hi/lo (current architectural HI/LO),
//        res_hi/res_lo (value HI/LO take when the operation commits).
// Covers signed/unsigned multiply, multiply-accumulate/subtract (mod 2^64) and divide.
// Divide by zero returns the incoming hi/lo so the commit leaves them untouched.
module multdiv_alu
  import multdiv_scheduler_pkg::*;
(
  input  logic [MdOpW-1:0] op,
  input  logic [31:0]      rs,
  input  logic [31:0]      rt,
  input  logic [31:0]      hi,
  input  logic [31:0]      lo,
  output logic [31:0]      res_hi,
  output logic [31:0]      res_lo
);

  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod, hilo;

  logic        div_signed;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_abs, rt_abs, divisor;
  logic [31:0] q_abs, r_abs, quot, rem;

  assign mul_signed = (op == OpMult) || (op == OpMadd) || (op == OpMsub);
  // Sign/zero extension to 64 bits makes the truncated product correct for both signednesses.
  assign mul_a = mul_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
  assign mul_b = mul_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
  assign prod  = mul_a * mul_b;
  assign hilo  = {hi, lo};

  // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_signed = (op == OpDiv);
  assign rs_neg     = div_signed & rs[31];
  assign rt_neg     = div_signed & rt[31];
  assign rs_abs     = rs_neg ? (32'd0 - rs) : rs;
  assign rt_abs     = rt_neg ? (32'd0 - rt) : rt;
  assign divisor    = (rt_abs == 32'd0) ? 32'd1 : rt_abs;
  assign q_abs      = rs_abs / divisor;
  assign r_abs      = rs_abs % divisor;
  assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_abs) : q_abs;
  assign rem        = rs_neg ? (32'd0 - r_abs) : r_abs;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if ((op == OpMult) || (op == OpMultu)) begin
      {res_hi, res_lo} = prod;
    end else if ((op == OpMadd) || (op == OpMaddu)) begin
      {res_hi, res_lo} = hilo + prod;
    end else if ((op == OpMsub) || (op == OpMsubu)) begin
      {res_hi, res_lo} = hilo - prod;
    end else if (is_div_op(op) && (rt != 32'd0)) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Multiply/divide unit scheduler for the E stage.
// Ports: clk, reset (synchronous, active-high), md (multdiv_scheduler_if.slave):
//   start_E/multdivop_E/rs_E/rt_E issue an op, md_use_D flags an MD-class instruction in D,
//   busy marks an op in flight, stall_md requests a D stall, hi/lo are architectural HI/LO.
// A multi-cycle op latches its result at the start edge and commits it to HI/LO when the
// latency counter expires, so HI/LO never show partial results.
// Optional: MULTDIV_CANCEL_EN adds md.cancel_E, which flushes an in-flight op and suppresses
// a same-cycle start (including mthi/mtlo).
module multdiv_scheduler
  import multdiv_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefaultMultCycles,
  parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
  input logic              clk,
  input logic              reset,
  multdiv_scheduler_if.slave md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  md_state_e   state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] alu_hi, alu_lo;
  logic        cancel;

`ifdef MULTDIV_CANCEL_EN
  assign cancel = md.cancel_E;
`else
  assign cancel = 1'b0;
`endif

  multdiv_alu u_alu (
    .op     (md.multdivop_E),
    .rs     (md.rs_E),
    .rt     (md.rt_E),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (alu_hi),
    .res_lo (alu_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md.start_E && !cancel) begin
          if (is_mul_op(md.multdivop_E) || is_div_op(md.multdivop_E)) begin
            pend_hi_d = alu_hi;
            pend_lo_d = alu_lo;
            cnt_d     = is_div_op(md.multdivop_E) ? cnt_t'(DIV_CYCLES) : cnt_t'(MULT_CYCLES);
            state_d   = StBusy;
          end else if (md.multdivop_E == OpMthi) begin
            hi_d = md.rs_E;
          end else if (md.multdivop_E == OpMtlo) begin
            lo_d = md.rs_E;
          end
        end
      end
      StBusy: begin
        // A start while busy is excluded by the hazard unit and is ignored here.
        if (cancel) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == cnt_t'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.busy     = (state_q == StBusy);
  assign md.stall_md = md.md_use_D & (md.start_E | md.busy);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: doc/multdiv_scheduler.md
Name: multdiv_scheduler

Overview:
Sequences the shared multiply/divide resource in the E stage of the 5-stage MIPS pipeline. Accepts one HI/LO operation per issue, holds the unit busy for a fixed latency, and commits results to the architectural HI/LO registers. Drives the MD stall request consumed by the D-stage hazard logic alongside the tuse/tnew checks.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_E  in  1  issue strobe for the instruction in E that uses the MD unit
multdivop_E  in  4  operation code from the shared constants
rs_E  in  32  forwarded rs operand
rt_E  in  32  forwarded rt operand
md_use_D  in  1  instruction in D is mfhi/mflo/mthi/mtlo/mult/div/madd class
busy  out  1  multi-cycle operation in flight
stall_md  out  1  stall request to hazard unit
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, state IDLE. Reset at any point aborts an in-flight operation. The pending result is discarded.
- Op codes:
  - 0 none
  - 1 mult, 2 multu, 3 div, 4 divu
  - 5 mthi, 6 mtlo
  - 7 madd, 8 maddu, 9 msub, 10 msubu
  - 11-15 are treated as none.
- States: IDLE and BUSY.
- IDLE, start_E=1, multi-cycle op:
  - latch the result computed from rs_E, rt_E and the current {hi,lo} into pending_hi/pending_lo
  - load counter = MULT_CYCLES or DIV_CYCLES
  - go to BUSY
- IDLE, start_E=1, op 5/6: hi (or lo) <= rs_E at this edge. No busy.
- start_E=1 with op 0 or 11-15: no effect.
- BUSY: counter decrements each edge. On the edge where counter==1, hi/lo <= pending values, busy -> 0, state -> IDLE. busy is therefore high for exactly N cycles after the start edge.
- hi/lo do not change while BUSY. mfhi/mflo never observe partial results.
- start_E=1 while BUSY: ignored. The hazard unit guarantees this cannot occur, and the bench asserts it.
- stall_md = md_use_D & (start_E | busy), combinational.
- Arithmetic:
  - mult/madd/msub: signed 32x32 -> 64.
  - multu/maddu/msubu: unsigned.
  - madd: {hi,lo} + product; msub: {hi,lo} - product. Both mod 2^64.
  - div/divu: lo = quotient, hi = remainder.
  - Signed div truncates toward zero; remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: hi/lo keep their prior values. Full DIV_CYCLES busy period still applies.
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MULT_CYCLES or DIV_CYCLES = 1: busy high for one cycle, then commit.

Optional Feature:
MULTDIV_CANCEL_EN
- With it: adds input cancel_E (1 bit), used for exception/interrupt flush.
  - In BUSY: discards the pending result at the next edge, busy -> 0, hi/lo unchanged.
  - Same cycle as start_E: the start is suppressed, including mthi/mtlo writes.
  - cancel_E has priority over completion on the counter==1 edge.
- Without it: no port. Every started operation commits.

Decomposition:
- Shared constants include: op codes 0-10, the 4-bit op width, and default cycle counts. Same file as the existing decode constants, so the decoder and this block agree.
- One combinational sub-module, multdiv_alu:
  - inputs: op, rs, rt, hi, lo
  - outputs: res_hi, res_lo
  - covers signed/unsigned multiply, accumulate, divide and the div-by-zero/overflow rules.
- The scheduler keeps only the FSM, counter, pending registers and HI/LO.

Test Plan:
- mult rs=0xFFFFFFFF rt=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=1, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. hi/lo unchanged at cycles 1-9.
- div rs=5 rt=0 after mthi 0x11/mtlo 0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- hi=0, lo=0xFFFFFFFF, then maddu rs=1 rt=1 -> hi=1, lo=0. Then msub rs=1 rt=1 -> hi=0, lo=0xFFFFFFFF.
- Stall: start mult, then md_use_D=1 (mflo) -> stall_md=1 for the start cycle and all 5 busy cycles, 0 afterward; md_use_D=0 -> stall_md=0 throughout.
- Reset asserted at busy cycle 3 of a div -> next cycle busy=0, hi=0, lo=0, no later commit. With MULTDIV_CANCEL_EN: cancel_E at cycle 3 -> busy=0, hi/lo keep their pre-op values.
